// File: rtl/reg_file_arbiter.sv
// Two-port arbiter/sequencer for the PIC register file (addresses RF_BASE..2^ADDR_W-1).
// Define REGARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (A over B).
module reg_file_arbiter #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 8,
   parameter int RF_BASE = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   output logic              gnt_a,
   output logic              done_a,
   input  logic              req_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              gnt_b,
   output logic              done_b,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              rf_write_en,
   output logic              rf_out_en,
   output logic [ADDR_W-1:0] rf_address,
   output logic [DATA_W-1:0] rf_data_in,
   input  logic [DATA_W-1:0] rf_data_out
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(RF_BASE);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t state;
   logic   owner_b;
   logic   bad_addr;
   logic   prio_b;
   logic   win_a;
   logic   win_b;
   logic   xfer_a;
   logic   xfer_b;

   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_bad;

`ifdef REGARB_ROUND_ROBIN_EN
   // prio_b set means A was granted last, so B wins the next tie
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         prio_b <= 1'b0;
      else if (xfer_a)
         prio_b <= 1'b1;
      else if (xfer_b)
         prio_b <= 1'b0;
   end
`else
   assign prio_b = 1'b0;
`endif

   assign win_a = req_a && (!req_b || !prio_b);
   assign win_b = req_b && (!req_a ||  prio_b);

   // Grants are combinational but forced low while reset is asserted
   assign gnt_a  = reset_n && (state == IDLE) && win_a;
   assign gnt_b  = reset_n && (state == IDLE) && win_b;
   assign xfer_a = req_a && gnt_a;
   assign xfer_b = req_b && gnt_b;

   always_comb begin
      sel_we    = we_a;
      sel_addr  = addr_a;
      sel_wdata = wdata_a;
      if (xfer_b) begin
         sel_we    = we_b;
         sel_addr  = addr_b;
         sel_wdata = wdata_b;
      end
      sel_bad = (sel_addr < BASE);
   end

   // The rf_* output registers double as the latched transaction
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         owner_b     <= 1'b0;
         bad_addr    <= 1'b0;
         done_a      <= 1'b0;
         done_b      <= 1'b0;
         rdata       <= '0;
         err         <= 1'b0;
         rf_write_en <= 1'b0;
         rf_out_en   <= 1'b0;
         rf_address  <= '0;
         rf_data_in  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer_a || xfer_b) begin
                  state       <= ACCESS;
                  owner_b     <= xfer_b;
                  bad_addr    <= sel_bad;
                  rf_write_en <= sel_we && !sel_bad;
                  rf_out_en   <= !sel_we && !sel_bad;
                  rf_address  <= sel_bad ? '0 : sel_addr;
                  rf_data_in  <= (sel_we && !sel_bad) ? sel_wdata : '0;
               end
            end
            ACCESS: begin
               state       <= RESP;
               rdata       <= rf_out_en ? rf_data_out : '0;
               err         <= bad_addr;
               done_a      <= !owner_b;
               done_b      <= owner_b;
               rf_write_en <= 1'b0;
               rf_out_en   <= 1'b0;
               rf_address  <= '0;
               rf_data_in  <= '0;
            end
            RESP: begin
               state  <= IDLE;
               done_a <= 1'b0;
               done_b <= 1'b0;
               rdata  <= '0;
               err    <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed bench for reg_file_arbiter with a behavioural register file model.
module tb_reg_file_arbiter;

   logic       clock;
   logic       reset_n;
   logic       req_a, we_a, req_b, we_b;
   logic [4:0] addr_a, addr_b;
   logic [7:0] wdata_a, wdata_b;
   logic       gnt_a, done_a, gnt_b, done_b;
   logic [7:0] rdata;
   logic       err;
   logic       rf_write_en, rf_out_en;
   logic [4:0] rf_address;
   logic [7:0] rf_data_in;
   wire  [7:0] rf_data_out;

   logic [7:0] rf_mem [0:31];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int we_cnt = 0, oe_cnt = 0, done_a_cnt = 0, viol = 0;
   logic [4:0] last_wa;
   logic [7:0] last_wd;

   reg_file_arbiter dut (
      .clock(clock), .reset_n(reset_n),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .gnt_a(gnt_a), .done_a(done_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .gnt_b(gnt_b), .done_b(done_b),
      .rdata(rdata), .err(err),
      .rf_write_en(rf_write_en), .rf_out_en(rf_out_en),
      .rf_address(rf_address), .rf_data_in(rf_data_in),
      .rf_data_out(rf_data_out)
   );

   wire [27:0] all_outs = {gnt_a, gnt_b, done_a, done_b, rf_write_en, rf_out_en,
                           rf_address, rf_data_in, rdata, err};

   assign rf_data_out = rf_out_en ? rf_mem[rf_address] : 8'hzz;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (rf_write_en) rf_mem[rf_address] <= rf_data_in;
   end

   always @(negedge clock) begin
      if (rf_write_en) begin
         we_cnt  = we_cnt + 1;
         last_wa = rf_address;
         last_wd = rf_data_in;
      end
      if (rf_out_en) oe_cnt = oe_cnt + 1;
      if (done_a) done_a_cnt = done_a_cnt + 1;
      if (rf_write_en && rf_out_en) viol = viol + 1;
      if (!rf_write_en && rf_data_in != 8'h00) viol = viol + 1;
      if (!done_a && !done_b && (err || rdata != 8'h00)) viol = viol + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic txn(input bit pb, input bit we, input logic [4:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic e, output int g, output int lat);
      int t;
      if (pb) begin req_b = 1; we_b = we; addr_b = a; wdata_b = d; end
      else    begin req_a = 1; we_a = we; addr_a = a; wdata_a = d; end
      #1;
      t = 0;
      while (!(pb ? gnt_b : gnt_a) && t < 20) begin @(negedge clock); #1; t++; end
      g = cyc;
      @(negedge clock);
      // inputs scrambled after transfer must have no effect
      if (pb) begin req_b = 0; we_b = ~we; addr_b = 5'd0; wdata_b = ~d; end
      else    begin req_a = 0; we_a = ~we; addr_a = 5'd0; wdata_a = ~d; end
      #1;
      t = 0;
      while (!(pb ? done_b : done_a) && t < 10) begin @(negedge clock); #1; t++; end
      lat = cyc - g;
      rd  = rdata;
      e   = err;
   endtask

   logic [7:0] rd, rd2;
   logic       e, e2;
   int         g, g2, lat, lat2, w0, o0, d0, t;
   logic [7:0] ord;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 8'h30 + 8'(i);
      reset_n = 0; req_a = 1; we_a = 0; addr_a = 5'd9; wdata_a = 0;
      req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
      repeat (3) @(negedge clock);
      #1;
      check("reset_outputs", 32'(all_outs), 32'h0);
      req_a = 0;
      @(negedge clock); reset_n = 1;
      @(negedge clock);

      // A write 9 then read 9
      w0 = we_cnt;
      txn(0, 1, 5'd9, 8'h5A, rd, e, g, lat);
      check("wr9_latency", 32'(lat), 32'd2);
      check("wr9_we_pulses", 32'(we_cnt - w0), 32'd1);
      check("wr9_addr", 32'(last_wa), 32'd9);
      check("wr9_data", 32'(last_wd), 32'h5A);
      check("wr9_err", 32'(e), 32'd0);
      check("wr9_rdata", 32'(rd), 32'h00);
      o0 = oe_cnt;
      txn(0, 0, 5'd9, 8'h00, rd, e, g, lat);
      check("rd9_latency", 32'(lat), 32'd2);
      check("rd9_rdata", 32'(rd), 32'h5A);
      check("rd9_err", 32'(e), 32'd0);
      check("rd9_oe_pulses", 32'(oe_cnt - o0), 32'd1);

      // B read of an unimplemented address
      w0 = we_cnt; o0 = oe_cnt;
      txn(1, 0, 5'd3, 8'h00, rd, e, g, lat);
      check("rd3_err", 32'(e), 32'd1);
      check("rd3_rdata", 32'(rd), 32'h00);
      check("rd3_no_strobes", 32'((we_cnt - w0) + (oe_cnt - o0)), 32'd0);
      check("rd3_latency", 32'(lat), 32'd2);

      // A write 31 and B read 31 requested together
      @(negedge clock);
      fork
         txn(0, 1, 5'd31, 8'hC3, rd, e, g, lat);
         txn(1, 0, 5'd31, 8'h00, rd2, e2, g2, lat2);
      join
      check("wr31_err", 32'(e), 32'd0);
      check("rd31_rdata", 32'(rd2), 32'hC3);
      check("rd31_err", 32'(e2), 32'd0);
      check("grant_spacing", 32'(g2 - g), 32'd3);

      // Both ports hold requests for 4 transactions each
      @(negedge clock);
      ord = 8'h00;
      fork
         begin
            logic [7:0] r; logic ee; int gg, ll;
            for (int i = 0; i < 4; i++) begin
               txn(0, 1, 5'(16 + i), 8'(8'h80 + i), r, ee, gg, ll);
               ord = {ord[6:0], 1'b0};
            end
         end
         begin
            logic [7:0] r; logic ee; int gg, ll;
            for (int j = 0; j < 4; j++) begin
               txn(1, 1, 5'(24 + j), 8'(8'h90 + j), r, ee, gg, ll);
               ord = {ord[6:0], 1'b1};
            end
         end
      join
`ifdef REGARB_ROUND_ROBIN_EN
      check("grant_order", 32'(ord), 32'h55);
`else
      check("grant_order", 32'(ord), 32'h0F);
`endif
      check("arb_mem_a3", 32'(rf_mem[19]), 32'h83);
      check("arb_mem_b0", 32'(rf_mem[24]), 32'h90);

      // Reset asserted during ACCESS of an A write to 12
      @(negedge clock);
      req_a = 1; we_a = 1; addr_a = 5'd12; wdata_a = 8'hFF;
      #1;
      t = 0;
      while (!gnt_a && t < 20) begin @(negedge clock); #1; t++; end
      @(negedge clock);
      req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
      #1;
      check("rst_access_we", 32'(rf_write_en), 32'd1);
      d0 = done_a_cnt;
      reset_n = 0;
      #1;
      check("rst_async_outputs", 32'(all_outs), 32'h0);
      @(negedge clock); reset_n = 1;
      repeat (4) @(negedge clock);
      check("rst_no_done", 32'(done_a_cnt - d0), 32'd0);
      txn(0, 0, 5'd12, 8'h00, rd, e, g, lat);
      check("rst_rd12", 32'(rd), 32'h3C);

      // Range boundaries
      txn(0, 1, 5'd8, 8'h11, rd, e, g, lat);
      check("wr8_err", 32'(e), 32'd0);
      txn(1, 0, 5'd8, 8'h00, rd, e, g, lat);
      check("rd8_rdata", 32'(rd), 32'h11);
      check("rd8_err", 32'(e), 32'd0);
      txn(1, 0, 5'd31, 8'h00, rd, e, g, lat);
      check("rd31b_rdata", 32'(rd), 32'hC3);
      w0 = we_cnt;
      txn(0, 1, 5'd7, 8'hEE, rd, e, g, lat);
      check("wr7_err", 32'(e), 32'd1);
      check("wr7_no_write", 32'(we_cnt - w0), 32'd0);
      check("wr7_mem_intact", 32'(rf_mem[7]), 32'h37);
      txn(0, 0, 5'd7, 8'h00, rd, e, g, lat);
      check("rd7_err", 32'(e), 32'd1);
      check("rd7_rdata", 32'(rd), 32'h00);

      repeat (2) @(negedge clock);
      check("invariants", 32'(viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
